pb_conditioner: RTL and testbench
=================================

PB_CONDITIONER -- requirements
Module: pb_conditioner

Interface
REQ-001 SHALL have parameter CLK_HZ, default 100_000_000, meaning the basys_clock frequency in Hz.
REQ-002 SHALL have parameter DEBOUNCE_MS, default 20, meaning the number of consecutive 1 ms ticks an input must be stable to change level.
REQ-003 SHALL have parameter REPEAT_DELAY_MS, default 400, meaning the hold time before the first auto-repeat pulse.
REQ-004 SHALL have parameter REPEAT_RATE_MS, default 100, meaning the interval between subsequent auto-repeat pulses.
REQ-005 SHALL have parameter REPEAT_MASK, default 5'b01111, meaning the buttons eligible for auto-repeat (up/down/left/right; center excluded).
REQ-006 SHALL have port basys_clock, input, 1 bit: the single system clock; all logic is on its rising edge.
REQ-007 SHALL have port reset_n, input, 1 bit: asynchronous, active-low reset.
REQ-008 SHALL have port pb_raw, input, 5 bits: raw asynchronous pushbuttons, index 0 up, 1 down, 2 left, 3 right, 4 center.
REQ-009 SHALL have port pb_level, output, 5 bits: debounced button state.
REQ-010 SHALL have port pb_press, output, 5 bits: one-cycle pulse per accepted press or auto-repeat event.
REQ-011 SHALL have port pb_release, output, 5 bits: one-cycle pulse on a debounced release.

Function
REQ-012 SHALL pass each pb_raw bit through a two-flop synchronizer before any other use.
REQ-013 SHALL generate a shared one-cycle ms_tick every CLK_HZ/1000 cycles from a prescaler that wraps at CLK_HZ/1000-1.
REQ-014 SHALL, per channel, count ms_ticks while the synchronized input differs from pb_level, and clear the count on any cycle where they match.
REQ-015 SHALL toggle pb_level on the cycle the count reaches DEBOUNCE_MS, then clear the count.
REQ-016 SHALL assert pb_press for exactly one cycle, the cycle after pb_level rises; likewise pb_release after pb_level falls.
REQ-017 SHALL run a per-channel FSM: IDLE -> HELD on level rise; HELD -> REPEAT once REPEAT_DELAY_MS ticks elapse while held; REPEAT emits a press pulse every REPEAT_RATE_MS ticks; any state -> IDLE on level fall.
REQ-018 SHALL emit the first repeat pulse exactly REPEAT_DELAY_MS ticks after the initial press pulse, with repeat and release pulses never in the same cycle.
REQ-019 SHALL keep channels fully independent; simultaneous presses on several buttons produce simultaneous pulses.
REQ-020 SHALL keep channels with REPEAT_MASK bit 0 in IDLE/HELD only, with no repeat pulses.
REQ-021 SHALL size all counters with $clog2 of their maximum value and never let them wrap past that maximum.

Reset
REQ-022 SHALL, while reset_n=0, force pb_level, pb_press and pb_release to 0 and clear the synchronizers, prescaler, counters and FSMs (to IDLE).
REQ-023 SHALL, for a button held across reset release, report a press only after a full DEBOUNCE_MS of stable input.
REQ-024 SHALL abandon a debounce or repeat in progress when reset asserts mid-operation, with no pulse emitted.

Configuration
REQ-025 SHALL, with PB_AUTOREPEAT_EN defined, implement HELD/REPEAT behaviour per REQ-017..REQ-020.
REQ-026 SHALL, without PB_AUTOREPEAT_EN, omit the repeat FSM and counters, with pb_press pulsing once per debounced rise only and REPEAT_* parameters ignored.

Structure
REQ-027 SHALL place the button index constants (PB_UP=0, PB_DOWN=1, PB_LEFT=2, PB_RIGHT=3, PB_CENTER=4), the NUM_PB=5 constant and the channel FSM state typedef in the shared package pb_pkg.
REQ-028 SHALL implement one channel (synchronizer, debounce, edge detect, repeat FSM) as sub-module pb_channel, instantiated 5 times alongside one shared prescaler.

Verification (CLK_HZ=10_000 so a tick occurs every 10 cycles; DEBOUNCE_MS=3, REPEAT_DELAY_MS=5, REPEAT_RATE_MS=2)
REQ-029 SHALL cover this scenario: pb_raw[0] toggles 4 times within 20 cycles, then stays 0 -> pb_level[0] stays 0 and no pb_press.
REQ-030 SHALL cover this scenario: pb_raw[4] held 1 for 200 cycles, then released -> one pb_press[4] about 30-40 cycles after assertion, no repeat, and one pb_release[4] about 30-40 cycles after release.
REQ-031 SHALL cover this scenario, with PB_AUTOREPEAT_EN defined: pb_raw[3] held for 150 cycles -> the initial press, a repeat 50 cycles later, then repeats every 20 cycles until release.
REQ-032 SHALL cover this scenario, without PB_AUTOREPEAT_EN: the same stimulus as REQ-031 -> exactly one pb_press[3].
REQ-033 SHALL cover this scenario: pb_raw=5'b00011 asserted together -> pb_press[0] and pb_press[1] pulse in the same cycle.
REQ-034 SHALL cover this scenario: reset_n pulled low for 3 cycles in the middle of a debounce, with the button still held -> outputs are 0 during reset, and the press appears 3 ticks after reset release.

Source files
------------

// File: rtl/pb_pkg.sv
// pb_pkg: shared constants and types for the pushbutton conditioner.
//   Button index map, channel count, per-channel repeat FSM state type,
//   and a small helper for sizing counters.
package pb_pkg;

  localparam int PB_UP     = 0;
  localparam int PB_DOWN   = 1;
  localparam int PB_LEFT   = 2;
  localparam int PB_RIGHT  = 3;
  localparam int PB_CENTER = 4;
  localparam int NUM_PB    = 5;

  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_HELD   = 2'd1,
    ST_REPEAT = 2'd2
  } pb_state_t;

  // Bits needed to hold values 0..max_val inclusive (at least 1).
  function automatic int cnt_w(input int max_val);
    return (max_val < 1) ? 1 : $clog2(max_val + 1);
  endfunction

endpackage

// File: rtl/pb_channel.sv
// pb_channel: one pushbutton channel.
//   2-flop synchronizer -> ms-tick debouncer -> edge pulses, plus the
//   optional auto-repeat FSM (compiled in with PB_AUTOREPEAT_EN).
// Ports:
//   i_clk, i_rst_n  clock / async active-low reset
//   i_tick          shared 1 ms strobe
//   i_raw           raw asynchronous button input
//   o_level         debounced level
//   o_press         one-cycle pulse on press or auto-repeat
//   o_release       one-cycle pulse on debounced release
module pb_channel
  import pb_pkg::*;
#(
  parameter int DEBOUNCE_MS = 20
`ifdef PB_AUTOREPEAT_EN
  ,
  parameter int   REPEAT_DELAY_MS = 400,
  parameter int   REPEAT_RATE_MS  = 100,
  parameter logic REPEAT_EN       = 1'b1
`endif
) (
  input  logic i_clk,
  input  logic i_rst_n,
  input  logic i_tick,
  input  logic i_raw,
  output logic o_level,
  output logic o_press,
  output logic o_release
);

  localparam int DW = cnt_w(DEBOUNCE_MS);

  logic          r_s1, r_s2;
  logic          r_level, r_level_d;
  logic          r_press, r_release;
  logic [DW-1:0] r_cnt;
  logic          w_rise, w_fall;

  assign w_rise = r_level & ~r_level_d;
  assign w_fall = ~r_level & r_level_d;

  // Synchronizer, debounce counter and level/edge registers.
  // The count only advances on ticks while the input disagrees with the
  // current level; any agreeing cycle restarts the stability window.
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_s1      <= 1'b0;
      r_s2      <= 1'b0;
      r_level   <= 1'b0;
      r_level_d <= 1'b0;
      r_release <= 1'b0;
      r_cnt     <= '0;
    end else begin
      r_s1      <= i_raw;
      r_s2      <= r_s1;
      r_level_d <= r_level;
      r_release <= w_fall;
      if (r_s2 == r_level) begin
        r_cnt <= '0;
      end else if (i_tick) begin
        if (r_cnt == DW'(DEBOUNCE_MS - 1)) begin
          r_level <= ~r_level;
          r_cnt   <= '0;
        end else begin
          r_cnt <= r_cnt + DW'(1);
        end
      end
    end
  end

`ifdef PB_AUTOREPEAT_EN
  localparam int RMAX = (REPEAT_DELAY_MS > REPEAT_RATE_MS) ? REPEAT_DELAY_MS : REPEAT_RATE_MS;
  localparam int RW   = cnt_w(RMAX);

  pb_state_t     r_state;
  logic [RW-1:0] r_rcnt;
  logic          r_rep;

  // Repeat FSM. r_rep is a one-cycle request that is turned into a press
  // pulse one cycle later, which lines repeat pulses up with the edge
  // pulse timing (both land one cycle after the tick that caused them).
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_state <= ST_IDLE;
      r_rcnt  <= '0;
      r_rep   <= 1'b0;
    end else begin
      r_rep <= 1'b0;
      if (!r_level) begin
        r_state <= ST_IDLE;
        r_rcnt  <= '0;
      end else begin
        case (r_state)
          ST_IDLE: if (w_rise) begin
            r_state <= ST_HELD;
            r_rcnt  <= '0;
          end
          ST_HELD: if (REPEAT_EN && i_tick) begin
            if (r_rcnt == RW'(REPEAT_DELAY_MS - 1)) begin
              r_state <= ST_REPEAT;
              r_rcnt  <= '0;
              r_rep   <= 1'b1;
            end else begin
              r_rcnt <= r_rcnt + RW'(1);
            end
          end
          ST_REPEAT: if (i_tick) begin
            if (r_rcnt == RW'(REPEAT_RATE_MS - 1)) begin
              r_rcnt <= '0;
              r_rep  <= 1'b1;
            end else begin
              r_rcnt <= r_rcnt + RW'(1);
            end
          end
          default: r_state <= ST_IDLE;
        endcase
      end
    end
  end

  // A repeat requested on the same tick that drops the level is
  // suppressed, so repeat and release never coincide.
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) r_press <= 1'b0;
    else          r_press <= w_rise | (r_rep & r_level);
  end
`else
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) r_press <= 1'b0;
    else          r_press <= w_rise;
  end
`endif

  assign o_level   = r_level;
  assign o_press   = r_press;
  assign o_release = r_release;

endmodule

// File: rtl/pb_conditioner.sv
// pb_conditioner: five-button debouncer with press/release pulses and
// optional auto-repeat on the directional buttons.
//   Build option: define PB_AUTOREPEAT_EN to enable HELD/REPEAT behaviour;
//   without it each debounced rise yields exactly one press pulse.
// Ports:
//   basys_clock  system clock (rising edge)
//   reset_n      async active-low reset
//   pb_raw[4:0]  raw buttons: 0 up, 1 down, 2 left, 3 right, 4 center
//   pb_level     debounced levels
//   pb_press     one-cycle press / auto-repeat pulses
//   pb_release   one-cycle release pulses
module pb_conditioner
  import pb_pkg::*;
#(
  parameter int                CLK_HZ          = 100_000_000,
  parameter int                DEBOUNCE_MS     = 20,
  parameter int                REPEAT_DELAY_MS = 400,
  parameter int                REPEAT_RATE_MS  = 100,
  parameter logic [NUM_PB-1:0] REPEAT_MASK     = 5'b01111
) (
  input  logic              basys_clock,
  input  logic              reset_n,
  input  logic [NUM_PB-1:0] pb_raw,
  output logic [NUM_PB-1:0] pb_level,
  output logic [NUM_PB-1:0] pb_press,
  output logic [NUM_PB-1:0] pb_release
);

  localparam int PRE_MAX = CLK_HZ / 1000 - 1;
  localparam int PW      = cnt_w(PRE_MAX);

  logic [PW-1:0] r_pre;
  logic          w_tick;

  // Shared 1 ms prescaler; tick is high on the wrap cycle.
  assign w_tick = (r_pre == PW'(PRE_MAX));

  always_ff @(posedge basys_clock or negedge reset_n) begin
    if (!reset_n)    r_pre <= '0;
    else if (w_tick) r_pre <= '0;
    else             r_pre <= r_pre + PW'(1);
  end

`ifndef PB_AUTOREPEAT_EN
  // Repeat settings have no effect in this build.
  logic w_unused_cfg;
  assign w_unused_cfg = ^{REPEAT_MASK, 32'(REPEAT_DELAY_MS), 32'(REPEAT_RATE_MS)};
`endif

  for (genvar g = 0; g < NUM_PB; g++) begin : g_ch
    pb_channel #(
      .DEBOUNCE_MS     (DEBOUNCE_MS)
`ifdef PB_AUTOREPEAT_EN
      ,
      .REPEAT_DELAY_MS (REPEAT_DELAY_MS),
      .REPEAT_RATE_MS  (REPEAT_RATE_MS),
      .REPEAT_EN       (REPEAT_MASK[g])
`endif
    ) u_ch (
      .i_clk     (basys_clock),
      .i_rst_n   (reset_n),
      .i_tick    (w_tick),
      .i_raw     (pb_raw[g]),
      .o_level   (pb_level[g]),
      .o_press   (pb_press[g]),
      .o_release (pb_release[g])
    );
  end

endmodule

// File: tb/tb_pb_conditioner.sv
// tb_pb_conditioner: self-checking bench for pb_conditioner.
// Edges are numbered from reset release (edge 1 is the first rising edge
// after release). A rule-based model predicts level changes from the raw
// input history: the level flips on the DEBOUNCE_MS-th tick edge after the
// last edge at which the synchronized input agreed with the level.
module tb_pb_conditioner;

  localparam int            CLK_HZ = 10_000;
  localparam int            DEB    = 3;
  localparam int            RD     = 5;
  localparam int            RR     = 2;
  localparam logic [4:0]    MASK   = 5'b01111;
  localparam int            TICK   = CLK_HZ / 1000;

  logic       basys_clock = 1'b0;
  logic       reset_n;
  logic [4:0] pb_raw;
  logic [4:0] pb_level, pb_press, pb_release;

  pb_conditioner #(
    .CLK_HZ(CLK_HZ), .DEBOUNCE_MS(DEB), .REPEAT_DELAY_MS(RD),
    .REPEAT_RATE_MS(RR), .REPEAT_MASK(MASK)
  ) dut (
    .basys_clock(basys_clock), .reset_n(reset_n), .pb_raw(pb_raw),
    .pb_level(pb_level), .pb_press(pb_press), .pb_release(pb_release)
  );

  always #5 basys_clock = ~basys_clock;

  int errors = 0;
  int checks = 0;
  int cyc    = 0;

  logic [4:0] raw_at [0:8191];

  // model state
  logic [4:0] m_lvl, m_rise_prev, m_fall_prev, m_rep_prev, exp_press, exp_rel;
  int         m_L    [5];
  int         m_nrep [5];

  // observed DUT activity per channel since last reset
  int   press_cnt [5];
  int   rel_cnt   [5];
  int   first_press [5];
  int   second_press [5];
  int   first_rel [5];
  logic [4:0] lvl_seen;

  task automatic model_reset();
    m_lvl = '0; m_rise_prev = '0; m_fall_prev = '0; m_rep_prev = '0;
    for (int c = 0; c < 5; c++) begin
      m_L[c] = 0; m_nrep[c] = 0;
      press_cnt[c] = 0; rel_cnt[c] = 0;
      first_press[c] = -1; second_press[c] = -1; first_rel[c] = -1;
    end
    lvl_seen = '0;
  endtask

  task automatic model_edge(input int e);
    logic s2;
    exp_press = m_rise_prev | m_rep_prev;
    exp_rel   = m_fall_prev;
    m_rise_prev = '0; m_fall_prev = '0; m_rep_prev = '0;
    for (int c = 0; c < 5; c++) begin
      s2 = (e >= 3) ? raw_at[e-2][c] : 1'b0;
      if (s2 == m_lvl[c]) begin
        m_L[c] = e;
      end else if (e == (m_L[c] / TICK + 1) * TICK + TICK * (DEB - 1)) begin
        m_lvl[c] = ~m_lvl[c];
        m_L[c]   = e;
        if (m_lvl[c]) begin
          m_rise_prev[c] = 1'b1;
          m_nrep[c]      = e + TICK * RD;
        end else begin
          m_fall_prev[c] = 1'b1;
        end
      end
`ifdef PB_AUTOREPEAT_EN
      if (MASK[c] && m_lvl[c] && !m_rise_prev[c] && e == m_nrep[c]) begin
        m_rep_prev[c] = 1'b1;
        m_nrep[c]     = m_nrep[c] + TICK * RR;
      end
`endif
    end
  endtask

  // Called at a negedge: drive next raw value, advance one edge, check.
  task automatic step(input logic [4:0] nxt);
    pb_raw = nxt;
    raw_at[cyc+1] = nxt;
    @(posedge basys_clock);
    cyc++;
    model_edge(cyc);
    @(negedge basys_clock);
    checks++;
    if ({pb_level, pb_press, pb_release} !== {m_lvl, exp_press, exp_rel}) begin
      errors++;
      $display("FAIL model edge=%0d got lvl=%b prs=%b rel=%b want lvl=%b prs=%b rel=%b",
               cyc, pb_level, pb_press, pb_release, m_lvl, exp_press, exp_rel);
    end
    for (int c = 0; c < 5; c++) begin
      if (pb_press[c]) begin
        if (press_cnt[c] == 0) first_press[c] = cyc;
        else if (press_cnt[c] == 1) second_press[c] = cyc;
        press_cnt[c]++;
      end
      if (pb_release[c]) begin
        if (rel_cnt[c] == 0) first_rel[c] = cyc;
        rel_cnt[c]++;
      end
      if (pb_level[c]) lvl_seen[c] = 1'b1;
    end
  endtask

  // Called at a negedge; holds reset n cycles checking outputs are 0.
  task automatic do_reset(input int n);
    reset_n = 1'b0;
    for (int i = 0; i < n; i++) begin
      @(posedge basys_clock);
      @(negedge basys_clock);
      checks++;
      if ({pb_level, pb_press, pb_release} !== 15'd0) begin
        errors++;
        $display("FAIL reset_outputs got lvl=%b prs=%b rel=%b want all 0",
                 pb_level, pb_press, pb_release);
      end
    end
    reset_n = 1'b1;
    cyc = 0;
    model_reset();
  endtask

  task automatic test_reset();
    pb_raw = 5'b10101;
    do_reset(3);
    for (int i = 0; i < 20; i++) step(5'b00000);
  endtask

  task automatic test_glitch();
    logic [4:0] pat;
    do_reset(2);
    pat = 5'b00000;
    for (int i = 0; i < 20; i++) begin
      if (i == 2 || i == 6 || i == 11 || i == 15) pat[0] = ~pat[0];
      step(pat);
    end
    for (int i = 0; i < 60; i++) step(5'b00000);
    checks++;
    if (press_cnt[0] !== 0 || lvl_seen[0] !== 1'b0) begin
      errors++;
      $display("FAIL glitch presses=%0d level_seen=%b want 0/0", press_cnt[0], lvl_seen[0]);
    end
  endtask

  task automatic test_center_hold();
    do_reset(2);
    for (int i = 0; i < 200; i++) step(5'b10000);
    for (int i = 0; i < 60; i++)  step(5'b00000);
    checks++;
    if (press_cnt[4] !== 1 || rel_cnt[4] !== 1) begin
      errors++;
      $display("FAIL center_count presses=%0d releases=%0d want 1/1", press_cnt[4], rel_cnt[4]);
    end
    checks++;
    if (first_press[4] - 1 < 30 || first_press[4] - 1 > 40) begin
      errors++;
      $display("FAIL center_press_lat got %0d want 30..40", first_press[4] - 1);
    end
    checks++;
    if (first_rel[4] - 201 < 30 || first_rel[4] - 201 > 40) begin
      errors++;
      $display("FAIL center_rel_lat got %0d want 30..40", first_rel[4] - 201);
    end
  endtask

  task automatic test_autorepeat();
    do_reset(2);
    for (int i = 0; i < 150; i++) step(5'b01000);
    for (int i = 0; i < 50; i++)  step(5'b00000);
`ifdef PB_AUTOREPEAT_EN
    // presses at edges 31, 81, 101, 121, 141, 161; level falls at 180
    checks++;
    if (press_cnt[3] !== 6) begin
      errors++;
      $display("FAIL repeat_count got %0d want 6", press_cnt[3]);
    end
    checks++;
    if (second_press[3] - first_press[3] !== 50) begin
      errors++;
      $display("FAIL repeat_delay got %0d want 50", second_press[3] - first_press[3]);
    end
`else
    checks++;
    if (press_cnt[3] !== 1) begin
      errors++;
      $display("FAIL norepeat_count got %0d want 1", press_cnt[3]);
    end
`endif
    checks++;
    if (rel_cnt[3] !== 1) begin
      errors++;
      $display("FAIL repeat_release got %0d want 1", rel_cnt[3]);
    end
  endtask

  task automatic test_simultaneous();
    do_reset(2);
    for (int i = 0; i < 45; i++) step(5'b00011);
    for (int i = 0; i < 45; i++) step(5'b00000);
    checks++;
    if (press_cnt[0] !== 1 || press_cnt[1] !== 1 || first_press[0] !== first_press[1]
        || first_press[0] !== 31) begin
      errors++;
      $display("FAIL simultaneous cnt0=%0d cnt1=%0d at %0d/%0d want 1/1 at 31/31",
               press_cnt[0], press_cnt[1], first_press[0], first_press[1]);
    end
  endtask

  task automatic test_reset_mid();
    do_reset(2);
    for (int i = 0; i < 15; i++) step(5'b00100);
    checks++;
    if (press_cnt[2] !== 0 || lvl_seen[2] !== 1'b0) begin
      errors++;
      $display("FAIL midreset_pre presses=%0d lvl=%b want 0/0", press_cnt[2], lvl_seen[2]);
    end
    do_reset(3);
    for (int i = 0; i < 40; i++) step(5'b00100);
    checks++;
    if (press_cnt[2] !== 1 || first_press[2] !== 3 * TICK + 1) begin
      errors++;
      $display("FAIL midreset_press cnt=%0d at %0d want 1 at %0d",
               press_cnt[2], first_press[2], 3 * TICK + 1);
    end
    for (int i = 0; i < 40; i++) step(5'b00000);
  endtask

  task automatic test_random();
    logic [4:0] r;
    do_reset(2);
    r = '0;
    for (int i = 0; i < 1500; i++) begin
      for (int c = 0; c < 5; c++)
        if ($urandom_range(0, 39) == 0) r[c] = ~r[c];
      step(r);
    end
    for (int i = 0; i < 60; i++) step(5'b00000);
  endtask

  initial begin
    reset_n = 1'b0;
    pb_raw  = '0;
    model_reset();
    @(negedge basys_clock);
    test_reset();
    test_glitch();
    test_center_hold();
    test_autorepeat();
    test_simultaneous();
    test_reset_mid();
    test_random();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
